mem_access_ctrl: RTL and testbench

- Memory-stage load/store controller between the pipeline's memory stage and the data bus.
- Accepts one access per request: memMode, byte address and store data.
- Forms the aligned bus request: 8-byte address, MSIZE8, byte strobe and lane-shifted write data.
- Sequences the dbus valid/addr_ok/data_ok handshake, extracts and extends load data, and stalls the pipeline until the access retires.

---
 rtl/mem_access_ctrl.sv | 156 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller: builds an aligned 8-byte bus request,
// runs the valid/data_ok handshake and returns extended load data.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [3:0]  mem_mode,
  input  logic [63:0] mem_addr,
  input  logic [63:0] mem_wdata,
  output logic        mem_done,
  output logic [63:0] mem_rdata,
  output logic        mem_misalign,
  output logic        stall,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data
);

  localparam logic [2:0] MSIZE8 = 3'b011;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_reg;
  logic [3:0]  mode_reg;
  logic [2:0]  off_reg;

  logic        is_store;
  logic        is_mem;
  logic        misalign;
  logic [7:0]  strobe_base;
  logic [63:0] width_mask;
  logic [7:0]  strobe_next;
  logic [63:0] data_next;
  logic [63:0] shifted;
  logic [63:0] load_value;

  // The address handshake does not change the request; only data_ok retires it.
  logic unused_addr_ok;
  assign unused_addr_ok = dresp_addr_ok;

  assign is_store = mem_mode[3];
  assign is_mem   = (~mem_mode[3] & (mem_mode[2:0] != 3'b111)) | (mem_mode[3] & ~mem_mode[2]);

  always_comb begin
    strobe_base = 8'h01;
    width_mask  = 64'h0000_0000_0000_00FF;
    misalign    = 1'b0;
    case (mem_mode[1:0])
      2'b00: begin
        strobe_base = 8'h01;
        width_mask  = 64'h0000_0000_0000_00FF;
        misalign    = 1'b0;
      end
      2'b01: begin
        strobe_base = 8'h03;
        width_mask  = 64'h0000_0000_0000_FFFF;
        misalign    = mem_addr[0];
      end
      2'b10: begin
        strobe_base = 8'h0F;
        width_mask  = 64'h0000_0000_FFFF_FFFF;
        misalign    = |mem_addr[1:0];
      end
      default: begin
        strobe_base = 8'hFF;
        width_mask  = 64'hFFFF_FFFF_FFFF_FFFF;
        misalign    = |mem_addr[2:0];
      end
    endcase
  end

  assign strobe_next = is_store ? (strobe_base << mem_addr[2:0]) : 8'h00;
  assign data_next   = is_store ? ((mem_wdata & width_mask) << {mem_addr[2:0], 3'b000}) : 64'h0;

  // Load field lives at byte lane off_reg of the aligned response word.
  assign shifted = dresp_data >> {off_reg, 3'b000};

  always_comb begin
    load_value = 64'h0;
    case (mode_reg)
      4'b0000: load_value = {{56{shifted[7]}},  shifted[7:0]};
      4'b0001: load_value = {{48{shifted[15]}}, shifted[15:0]};
      4'b0010: load_value = {{32{shifted[31]}}, shifted[31:0]};
      4'b0011: load_value = shifted;
      4'b0100: load_value = {56'h0, shifted[7:0]};
      4'b0101: load_value = {48'h0, shifted[15:0]};
      4'b0110: load_value = {32'h0, shifted[31:0]};
      default: load_value = 64'h0;
    endcase
  end

  assign stall = mem_valid & ~mem_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      mode_reg     <= 4'h0;
      off_reg      <= 3'h0;
      mem_done     <= 1'b0;
      mem_misalign <= 1'b0;
      mem_rdata    <= 64'h0;
      dreq_valid   <= 1'b0;
      dreq_addr    <= 64'h0;
      dreq_size    <= MSIZE8;
      dreq_strobe  <= 8'h00;
      dreq_data    <= 64'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          mem_done     <= 1'b0;
          mem_misalign <= 1'b0;
          if (mem_valid) begin
            if (!is_mem || misalign) begin
              state_reg    <= DONE;
              mem_done     <= 1'b1;
              mem_misalign <= is_mem & misalign;
              mem_rdata    <= 64'h0;
            end else begin
              state_reg   <= BUSY;
              mode_reg    <= mem_mode;
              off_reg     <= mem_addr[2:0];
              dreq_valid  <= 1'b1;
              dreq_addr   <= {mem_addr[63:3], 3'b000};
              dreq_strobe <= strobe_next;
              dreq_data   <= data_next;
            end
          end
        end
        BUSY: begin
          if (dresp_data_ok) begin
            state_reg   <= DONE;
            mem_done    <= 1'b1;
            mem_rdata   <= load_value;
            dreq_valid  <= 1'b0;
            dreq_addr   <= 64'h0;
            dreq_strobe <= 8'h00;
            dreq_data   <= 64'h0;
          end
        end
        default: begin
          // DONE lasts one cycle regardless of mem_valid so the held access is not reissued.
          state_reg    <= IDLE;
          mem_done     <= 1'b0;
          mem_misalign <= 1'b0;
          mem_rdata    <= 64'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: each access is driven, its bus request
// and retirement checked against hand-computed values.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic [3:0]  mem_mode;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_done;
  logic [63:0] mem_rdata;
  logic        mem_misalign;
  logic        stall;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_mode(mem_mode),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_done(mem_done),
    .mem_rdata(mem_rdata), .mem_misalign(mem_misalign), .stall(stall),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
    .dresp_data(dresp_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Aligned access: request checked on every cycle it is held, data_ok given
  // after req_cycles request cycles, then the DONE and following IDLE cycle.
  task automatic do_access(input string tag, input logic [3:0] mode, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [63:0] resp, input int req_cycles,
                           input logic [7:0] exp_strobe, input logic [63:0] exp_data,
                           input logic [63:0] exp_rdata);
    logic [63:0] exp_addr;
    exp_addr  = {addr[63:3], 3'b000};
    mem_valid = 1'b1;
    mem_mode  = mode;
    mem_addr  = addr;
    mem_wdata = wdata;
    for (int c = 0; c < req_cycles; c++) begin
      step();
      dresp_addr_ok = (c == 1);
      chk({tag, ".dreq_valid"}, {63'h0, dreq_valid}, 64'h1);
      chk({tag, ".dreq_addr"}, dreq_addr, exp_addr);
      chk({tag, ".dreq_strobe"}, {56'h0, dreq_strobe}, {56'h0, exp_strobe});
      chk({tag, ".dreq_data"}, dreq_data, exp_data);
      chk({tag, ".dreq_size"}, {61'h0, dreq_size}, 64'h3);
      chk({tag, ".busy_done"}, {63'h0, mem_done}, 64'h0);
      chk({tag, ".stall"}, {63'h0, stall}, 64'h1);
    end
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b1;
    dresp_data    = resp;
    step();
    dresp_data_ok = 1'b0;
    dresp_data    = 64'h0;
    chk({tag, ".mem_done"}, {63'h0, mem_done}, 64'h1);
    chk({tag, ".mem_rdata"}, mem_rdata, exp_rdata);
    chk({tag, ".misalign"}, {63'h0, mem_misalign}, 64'h0);
    chk({tag, ".dreq_drop"}, {63'h0, dreq_valid}, 64'h0);
    chk({tag, ".stall_off"}, {63'h0, stall}, 64'h0);
    step();
    chk({tag, ".done_once"}, {63'h0, mem_done}, 64'h0);
    chk({tag, ".no_reissue"}, {63'h0, dreq_valid}, 64'h0);
    mem_valid = 1'b0;
    $display("txn %s mode=%b addr=%h rdata=%h", tag, mode, addr, exp_rdata);
  endtask

  // Access that retires without a bus transfer (misaligned or non-memory).
  task automatic do_nobus(input string tag, input logic [3:0] mode, input logic [63:0] addr,
                          input logic exp_mis);
    mem_valid = 1'b1;
    mem_mode  = mode;
    mem_addr  = addr;
    mem_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    chk({tag, ".mem_done"}, {63'h0, mem_done}, 64'h1);
    chk({tag, ".misalign"}, {63'h0, mem_misalign}, {63'h0, exp_mis});
    chk({tag, ".mem_rdata"}, mem_rdata, 64'h0);
    chk({tag, ".no_req"}, {63'h0, dreq_valid}, 64'h0);
    step();
    chk({tag, ".done_once"}, {63'h0, mem_done}, 64'h0);
    chk({tag, ".no_req2"}, {63'h0, dreq_valid}, 64'h0);
    mem_valid = 1'b0;
    $display("txn %s mode=%b addr=%h misalign=%0d", tag, mode, addr, exp_mis);
  endtask

  initial begin
    reset = 1'b1;
    mem_valid = 1'b0;
    mem_mode = 4'h0;
    mem_addr = 64'h0;
    mem_wdata = 64'h0;
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data = 64'h0;
    step();
    step();
    reset = 1'b0;

    chk("rst.dreq_valid", {63'h0, dreq_valid}, 64'h0);
    chk("rst.dreq_strobe", {56'h0, dreq_strobe}, 64'h0);
    chk("rst.dreq_addr", dreq_addr, 64'h0);
    chk("rst.dreq_data", dreq_data, 64'h0);
    chk("rst.dreq_size", {61'h0, dreq_size}, 64'h3);
    chk("rst.mem_done", {63'h0, mem_done}, 64'h0);
    chk("rst.misalign", {63'h0, mem_misalign}, 64'h0);
    chk("rst.mem_rdata", mem_rdata, 64'h0);
    chk("rst.stall", {63'h0, stall}, 64'h0);

    do_access("sb", 4'b1000, 64'h8000_0005, 64'h12AB, 64'h0, 2,
              8'h20, 64'h0000_AB00_0000_0000, 64'h0);
    do_access("lb", 4'b0000, 64'h8000_0007, 64'h0, 64'h8000_0000_0000_0000, 1,
              8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80);
    do_access("lbu", 4'b0100, 64'h8000_0007, 64'h0, 64'h8000_0000_0000_0000, 1,
              8'h00, 64'h0, 64'h0000_0000_0000_0080);
    do_access("lw", 4'b0010, 64'h8000_0004, 64'h0, 64'hDEAD_BEEF_0000_0000, 1,
              8'h00, 64'h0, 64'hFFFF_FFFF_DEAD_BEEF);
    do_access("lwu", 4'b0110, 64'h8000_0004, 64'h0, 64'hDEAD_BEEF_0000_0000, 1,
              8'h00, 64'h0, 64'h0000_0000_DEAD_BEEF);
    do_nobus("lh_mis", 4'b0001, 64'h8000_0003, 1'b1);
    do_access("sd", 4'b1011, 64'h8000_1008, 64'h0123_4567_89AB_CDEF, 64'h0, 6,
              8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0);
    do_access("sh", 4'b1001, 64'h8000_000A, 64'hFFFF_1234, 64'h0, 1,
              8'h0C, 64'h0000_0000_1234_0000, 64'h0);
    do_access("sw", 4'b1010, 64'h8000_0004, 64'hAAAA_AAAA_CAFE_F00D, 64'h0, 1,
              8'hF0, 64'hCAFE_F00D_0000_0000, 64'h0);
    do_access("lh", 4'b0001, 64'h8000_0002, 64'h0, 64'h0000_0000_8001_0000, 1,
              8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001);
    do_access("lhu", 4'b0101, 64'h8000_0002, 64'h0, 64'h0000_0000_8001_0000, 1,
              8'h00, 64'h0, 64'h0000_0000_0000_8001);
    do_access("ld", 4'b0011, 64'h8000_0010, 64'h0, 64'h1122_3344_5566_7788, 1,
              8'h00, 64'h0, 64'h1122_3344_5566_7788);
    do_nobus("sw_mis", 4'b1010, 64'h8000_0006, 1'b1);
    do_nobus("nomem", 4'b0111, 64'h8000_0003, 1'b0);

    // Reset while BUSY abandons the transfer; a late data_ok must be ignored.
    mem_valid = 1'b1;
    mem_mode  = 4'b0011;
    mem_addr  = 64'h8000_0018;
    step();
    chk("rstbusy.dreq_valid", {63'h0, dreq_valid}, 64'h1);
    mem_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstbusy.dreq_drop", {63'h0, dreq_valid}, 64'h0);
    chk("rstbusy.dreq_addr", dreq_addr, 64'h0);
    chk("rstbusy.mem_done", {63'h0, mem_done}, 64'h0);
    dresp_data_ok = 1'b1;
    dresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    dresp_data_ok = 1'b0;
    dresp_data = 64'h0;
    chk("late_ok.mem_done", {63'h0, mem_done}, 64'h0);
    chk("late_ok.mem_rdata", mem_rdata, 64'h0);
    chk("late_ok.dreq_valid", {63'h0, dreq_valid}, 64'h0);
    $display("txn ld_reset abandoned addr=%h", 64'h8000_0018);
    do_access("lbu_after", 4'b0100, 64'h8000_0001, 64'h0, 64'h0000_0000_0000_FE00, 1,
              8'h00, 64'h0, 64'h0000_0000_0000_00FE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
